ucsbece154b_mem_arbiter: RTL
============================

Name: ucsbece154b_mem_arbiter

Overview:
- Shares the single external memory port between three requesters: D-cache (loads and stores), I-cache miss refill, and the next-line instruction prefetcher.
- Sits between the fetch/memory stages and the memory model.
- Arbitrates by fixed priority, sequences one request-acknowledge-burst transaction at a time, and steers returned read beats to the owner.
- Lets the fetch path abandon a prefetch after a branch misprediction without breaking the memory handshake.

Parameters:
- BLOCK_WORDS, 4, words per read burst (power of two, 2..16)
- ADDR_W, 32, address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- d_req_i  in  1  D-cache request, held until d_done_o
- d_we_i  in  1  1 = single-word store, 0 = block read
- d_addr_i  in  ADDR_W  D-cache address
- d_wdata_i  in  32  store data
- d_gnt_o  out  1  one-cycle pulse when D-cache wins arbitration
- d_valid_o  out  1  read beat valid for D-cache
- d_done_o  out  1  one-cycle pulse when the D transaction completes
- i_req_i  in  1  I-cache miss request, held until i_done_o
- i_addr_i  in  ADDR_W  I-cache miss address
- i_gnt_o  out  1  grant pulse
- i_valid_o  out  1  beat valid for I-cache
- i_done_o  out  1  completion pulse
- pf_req_i  in  1  prefetch request, held until pf_done_o or cancel
- pf_addr_i  in  ADDR_W  prefetch address
- pf_cancel_i  in  1  abandon the prefetch (misprediction)
- pf_gnt_o  out  1  grant pulse
- pf_valid_o  out  1  beat valid for prefetcher
- pf_done_o  out  1  completion pulse
- rdata_o  out  32  shared read data bus (mem_rdata_i registered)
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  32  memory write data
- mem_ack_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  read beat valid
- mem_rdata_i  in  32  read beat data

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, owner = none, beat counter = 0, cancel flag = 0.
  - All outputs 0, including rdata_o.
  - Reset asserted mid-transaction aborts it immediately; the memory model is reset together with the arbiter.
- States: IDLE, ISSUE, BURST, DRAIN.
- IDLE:
  - Fixed priority D > I > PF, evaluated on the request inputs of the current cycle.
  - On a win: latch owner, we, wdata and address. Read addresses are block-aligned: low log2(BLOCK_WORDS)+2 bits cleared. Store addresses are used as given.
  - Pulse the owner's gnt the same cycle; next state ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - mem_req_o = 1; mem_addr_o, mem_we_o and mem_wdata_o hold the latched values until the cycle mem_ack_i = 1.
  - Store: on ack, pulse d_done_o the next cycle; go IDLE.
  - Read: on ack, go BURST, or DRAIN if the cancel flag is set.
  - mem_req_o falls the cycle after ack.
  - A request cannot be withdrawn before ack.
- BURST:
  - Each mem_rvalid_i registers mem_rdata_i into rdata_o and pulses the owner's valid the next cycle.
  - The counter increments; the beat that makes count reach BLOCK_WORDS also pulses the owner's done together with the last valid.
  - Then: counter = 0, state IDLE.
  - Gaps between beats are allowed.
  - rvalid in IDLE or ISSUE is ignored.
- Cancel:
  - pf_cancel_i while owner = PF sets the cancel flag in ISSUE, or moves BURST to DRAIN.
  - A cancel beat arriving in the same cycle as an rvalid is not forwarded.
  - pf_cancel_i with owner != PF, or in IDLE, has no effect.
  - A same-cycle pf_req_i and pf_cancel_i in IDLE means PF is not eligible.
- DRAIN:
  - Counts the remaining beats to BLOCK_WORDS with all valid and done outputs held at 0; pf_done_o is never pulsed.
  - Then IDLE; the cancel flag is cleared.
- Back-to-back: the earliest re-grant is the cycle after done (one IDLE cycle between transactions).
- A pending request that arrives mid-transaction waits; it is not dropped.
- Counter width is log2(BLOCK_WORDS)+1; it never wraps past BLOCK_WORDS.
- At most one gnt, one valid and one done are high in any cycle.

Test Plan:
- Single I read: i_req_i with i_addr_i = 0x104, BLOCK_WORDS = 4 -> i_gnt_o pulse; mem_addr_o = 0x100 until ack. Beats 0xA0..0xA3 appear on rdata_o with 4 i_valid_o pulses, i_done_o on the 4th; then IDLE.
- Simultaneous d_req_i (load 0x200), i_req_i and pf_req_i -> D granted first; I granted in the cycle after d_done_o; PF granted only after i_done_o.
- Store: d_we_i = 1, d_addr_i = 0x1C, d_wdata_i = 0xDEADBEEF, mem_ack_i delayed 3 cycles -> mem_req_o/mem_we_o/addr/data stable for 4 cycles; d_done_o one cycle after ack; no valid pulses.
- Cancel in BURST: PF read with pf_cancel_i after beat 1 -> 1 pf_valid_o; remaining 3 beats drained silently; no pf_done_o; a pending i_req_i is granted after the 4th beat.
- Cancel before ack: pf_cancel_i in ISSUE -> mem_req_o still held until ack; all 4 beats drained; zero pf_valid_o.
- Asynchronous reset asserted in BURST after 2 beats -> all outputs 0 immediately without a clock edge; the next i_req_i after release gets a full 4-beat transaction.

Source files
------------

// File: rtl/ucsbece154b_mem_arbiter.sv
// ucsbece154b_mem_arbiter
// Shares the single external memory port between the D-cache, the I-cache
// refill path and the next-line prefetcher. One transaction is in flight at a
// time: arbitrate in IDLE, hold the request in ISSUE until the memory acks,
// then collect the read burst (BURST) or swallow it silently after a prefetch
// cancel (DRAIN).
//
// state | meaning
// IDLE  | no transaction; fixed-priority arbitration D > I > PF
// ISSUE | mem_req_o held with latched address/data until mem_ack_i
// BURST | forwarding read beats to the owner, counting to BLOCK_WORDS
// DRAIN | prefetch abandoned; counting remaining beats without forwarding

module ucsbece154b_mem_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_valid_o,
    output logic              d_done_o,

    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_valid_o,
    output logic              i_done_o,

    input  logic              pf_req_i,
    input  logic [ADDR_W-1:0] pf_addr_i,
    input  logic              pf_cancel_i,
    output logic              pf_gnt_o,
    output logic              pf_valid_o,
    output logic              pf_done_o,

    output logic [31:0]       rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = $clog2(BLOCK_WORDS) + 1;
    localparam int OFF_W = $clog2(BLOCK_WORDS) + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_D    = 2'd1;
    localparam logic [1:0] OWN_I    = 2'd2;
    localparam logic [1:0] OWN_PF   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_WORDS);

    // Per-requester vectors are ordered {D, I, PF}.
    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cancel_q, cancel_d;
    logic [2:0]        valid_q, valid_d;
    logic [2:0]        done_q, done_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [2:0]        gnt;
    logic              pf_eligible;
    logic              cancel_hit;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last_beat;

    // Reads fetch a whole block, so the word and byte offset bits are dropped.
    function automatic logic [ADDR_W-1:0] block_align(input logic [ADDR_W-1:0] a);
        block_align = {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    function automatic logic [2:0] owner_onehot(input logic [1:0] own);
        case (own)
            OWN_D:   owner_onehot = 3'b100;
            OWN_I:   owner_onehot = 3'b010;
            OWN_PF:  owner_onehot = 3'b001;
            default: owner_onehot = 3'b000;
        endcase
    endfunction

    // Fixed-priority arbitration. Grants are blocked while a done pulse is out,
    // because the finishing requester still holds its request that cycle.
    always_comb begin
        pf_eligible = pf_req_i & ~pf_cancel_i;
        gnt         = 3'b000;
        if ((state_q == S_IDLE) && (done_q == 3'b000) && !reset) begin
            if (d_req_i)          gnt = 3'b100;
            else if (i_req_i)     gnt = 3'b010;
            else if (pf_eligible) gnt = 3'b001;
        end
    end

    // Cancel only matters for a prefetch that owns the port; the beat counter
    // is shared by BURST and DRAIN so the memory burst is always fully consumed.
    always_comb begin
        cancel_hit = pf_cancel_i && (owner_q == OWN_PF);
        cnt_inc    = cnt_q + CNT_W'(1);
        last_beat  = (cnt_inc == CNT_LAST);
    end

    // Transaction sequencing and beat steering.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        cancel_d = cancel_q;
        valid_d  = 3'b000;
        done_d   = 3'b000;
        rdata_d  = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (gnt != 3'b000) begin
                    state_d  = S_ISSUE;
                    cnt_d    = '0;
                    cancel_d = 1'b0;
                    if (gnt[2]) begin
                        owner_d = OWN_D;
                        we_d    = d_we_i;
                        addr_d  = d_we_i ? d_addr_i : block_align(d_addr_i);
                        wdata_d = d_wdata_i;
                    end else if (gnt[1]) begin
                        owner_d = OWN_I;
                        we_d    = 1'b0;
                        addr_d  = block_align(i_addr_i);
                        wdata_d = '0;
                    end else begin
                        owner_d = OWN_PF;
                        we_d    = 1'b0;
                        addr_d  = block_align(pf_addr_i);
                        wdata_d = '0;
                    end
                end
            end

            S_ISSUE: begin
                // The request stays up until ack even when the prefetch is
                // abandoned; the burst is then drained instead of forwarded.
                if (cancel_hit) cancel_d = 1'b1;
                if (mem_ack_i) begin
                    if (we_q) begin
                        done_d  = 3'b100;
                        state_d = S_IDLE;
                        owner_d = OWN_NONE;
                    end else if (cancel_q || cancel_hit) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_BURST;
                    end
                end
            end

            S_BURST: begin
                if (cancel_hit) begin
                    // A beat landing with the cancel is counted but dropped.
                    cancel_d = 1'b1;
                    state_d  = S_DRAIN;
                    if (mem_rvalid_i) begin
                        cnt_d = cnt_inc;
                        if (last_beat) begin
                            cnt_d    = '0;
                            cancel_d = 1'b0;
                            state_d  = S_IDLE;
                            owner_d  = OWN_NONE;
                        end
                    end
                end else if (mem_rvalid_i) begin
                    rdata_d = mem_rdata_i;
                    valid_d = owner_onehot(owner_q);
                    cnt_d   = cnt_inc;
                    if (last_beat) begin
                        done_d  = owner_onehot(owner_q);
                        cnt_d   = '0;
                        state_d = S_IDLE;
                        owner_d = OWN_NONE;
                    end
                end
            end

            S_DRAIN: begin
                if (mem_rvalid_i) begin
                    cnt_d = cnt_inc;
                    if (last_beat) begin
                        cnt_d    = '0;
                        cancel_d = 1'b0;
                        state_d  = S_IDLE;
                        owner_d  = OWN_NONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset drops everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_NONE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            cancel_q <= 1'b0;
            valid_q  <= 3'b000;
            done_q   <= 3'b000;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            cancel_q <= cancel_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
        end
    end

    // Output mapping.
    always_comb begin
        d_gnt_o     = gnt[2];
        i_gnt_o     = gnt[1];
        pf_gnt_o    = gnt[0];
        d_valid_o   = valid_q[2];
        i_valid_o   = valid_q[1];
        pf_valid_o  = valid_q[0];
        d_done_o    = done_q[2];
        i_done_o    = done_q[1];
        pf_done_o   = done_q[0];
        rdata_o     = rdata_q;
        mem_req_o   = (state_q == S_ISSUE);
        mem_we_o    = (state_q == S_ISSUE) && we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
    end

endmodule
